access_arbiter: RTL and testbench

ACCESS_ARBITER -- requirements
Module: access_arbiter

---
 rtl/access_arbiter.sv | 161 ++++++++++++++++
 tb/tb_access_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/access_arbiter.sv
// access_arbiter: two-port resource arbiter with profile-based priority,
// bounded grant length (HOLD_MAX) and a forced idle gap (GAP_CYC) between grants.
// Optional feature macro: ACCESS_ARBITER_FAIR_RR_EN
//   defined   -> profile ties go to the port that was not served last (round-robin)
//   undefined -> profile ties always go to IE01
module access_arbiter #(
  parameter int HOLD_MAX = 15,  // 1..255
  parameter int GAP_CYC  = 1    // 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       REQ_IE01,
  input  logic       REQ_IE02,
  input  logic [1:0] PERF_IE01,
  input  logic [1:0] PERF_IE02,
  input  logic       RELEASE,
  output logic       GNT_IE01,
  output logic       GNT_IE02,
  output logic       BUSY,
  output logic       TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT1 = 2'd1,
    S_GNT2 = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);
  localparam logic [3:0] GAP_CYC_C  = 4'(GAP_CYC);

  // last_served encoding: 0 = IE01, 1 = IE02
  localparam logic LS_IE01 = 1'b0;
  localparam logic LS_IE02 = 1'b1;

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gap_q, gap_d;
  logic       last_q, last_d;
  logic       timeout_d;
  logic       gnt1_q, gnt2_q, busy_q, timeout_q;

  logic       pick2_s;       // winner when both requests are high: 1 = IE02
  logic       holder_req_s;  // request line of the port currently holding the grant

  // Tie-break decision for simultaneous requests, based on the priority profiles.
  always_comb begin
    pick2_s = 1'b0;
    if (PERF_IE02 > PERF_IE01) begin
      pick2_s = 1'b1;
    end else if (PERF_IE01 > PERF_IE02) begin
      pick2_s = 1'b0;
    end else begin
`ifdef ACCESS_ARBITER_FAIR_RR_EN
      // Round-robin: serve the port that was not granted most recently.
      pick2_s = (last_q == LS_IE02) ? 1'b0 : 1'b1;
`else
      pick2_s = 1'b0;
`endif
    end
  end

  // Select the request line belonging to the current holder.
  always_comb begin
    holder_req_s = 1'b0;
    case (state_q)
      S_GNT1:  holder_req_s = REQ_IE01;
      S_GNT2:  holder_req_s = REQ_IE02;
      default: holder_req_s = 1'b0;
    endcase
  end

  // Next-state logic for the FSM, hold/gap counters, last_served and TIMEOUT.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ_IE01 && REQ_IE02) begin
          hold_d = 8'd1;
          if (pick2_s) begin
            state_d = S_GNT2;
            last_d  = LS_IE02;
          end else begin
            state_d = S_GNT1;
            last_d  = LS_IE01;
          end
        end else if (REQ_IE01) begin
          state_d = S_GNT1;
          last_d  = LS_IE01;
          hold_d  = 8'd1;
        end else if (REQ_IE02) begin
          state_d = S_GNT2;
          last_d  = LS_IE02;
          hold_d  = 8'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GNT1, S_GNT2: begin
        if (RELEASE || !holder_req_s) begin
          // Normal end, including RELEASE coinciding with the hold limit.
          state_d = S_GAP;
          gap_d   = 4'd1;
        end else if (hold_q >= HOLD_MAX_C) begin
          // Holder still wants the resource: forced end.
          state_d   = S_GAP;
          gap_d     = 4'd1;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_GAP: begin
        // Requests are deliberately not looked at here.
        if (gap_q >= GAP_CYC_C) begin
          state_d = S_IDLE;
          gap_d   = 4'd0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any grant or gap at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hold_q    <= 8'd0;
      gap_q     <= 4'd0;
      last_q    <= LS_IE02;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      last_q    <= last_d;
      gnt1_q    <= (state_d == S_GNT1);
      gnt2_q    <= (state_d == S_GNT2);
      busy_q    <= (state_d != S_IDLE);
      timeout_q <= timeout_d;
    end
  end

  assign GNT_IE01 = gnt1_q;
  assign GNT_IE02 = gnt2_q;
  assign BUSY     = busy_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_access_arbiter.sv
// Directed self-checking bench for access_arbiter (HOLD_MAX=4, GAP_CYC=1).
// Expected tie order follows ACCESS_ARBITER_FAIR_RR_EN when it is defined.
module tb_access_arbiter;

  logic       clk;
  logic       reset;
  logic       req1, req2;
  logic [1:0] perf1, perf2;
  logic       rel;
  logic       gnt1, gnt2, busy, tmo;

  int n_checks;
  int n_fails;

  access_arbiter #(.HOLD_MAX(4), .GAP_CYC(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .REQ_IE01  (req1),
    .REQ_IE02  (req2),
    .PERF_IE01 (perf1),
    .PERF_IE02 (perf2),
    .RELEASE   (rel),
    .GNT_IE01  (gnt1),
    .GNT_IE02  (gnt2),
    .BUSY      (busy),
    .TIMEOUT   (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs plus grant exclusivity.
  task automatic chk_out(input string tag, input logic g1, input logic g2,
                         input logic b, input logic t);
    chk({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, g1});
    chk({tag, ".gnt2"}, {31'd0, gnt2}, {31'd0, g2});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".tmo"},  {31'd0, tmo},  {31'd0, t});
    chk({tag, ".mutex"}, {31'd0, gnt1 & gnt2}, 32'd0);
  endtask

  logic rr_g1, rr_g2;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1; req1 = 1'b0; req2 = 1'b0;
    perf1 = 2'd0; perf2 = 2'd0; rel = 1'b0;
`ifdef ACCESS_ARBITER_FAIR_RR_EN
    rr_g1 = 1'b0; rr_g2 = 1'b1;
`else
    rr_g1 = 1'b1; rr_g2 = 1'b0;
`endif

    // Reset state
    tick(); tick();
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // Single request, release, gap, requests ignored during gap
    reset = 1'b0; req2 = 1'b1;
    tick(); chk_out("single_gnt", 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); chk_out("single_hold", 1'b0, 1'b1, 1'b1, 1'b0);
    rel = 1'b1;
    tick(); rel = 1'b0;
    chk_out("rel_gap", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk_out("gap_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk_out("regrant", 1'b0, 1'b1, 1'b1, 1'b0);
    req2 = 1'b0;
    tick(); chk_out("drop_gap", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk_out("drop_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Profile priority 2/3 -> IE02, profile change mid-grant has no effect
    req1 = 1'b1; req2 = 1'b1; perf1 = 2'd2; perf2 = 2'd3;
    tick(); chk_out("prio23", 1'b0, 1'b1, 1'b1, 1'b0);
    perf1 = 2'd3; perf2 = 2'd0;
    tick(); chk_out("prio_frozen", 1'b0, 1'b1, 1'b1, 1'b0);
    rel = 1'b1; req1 = 1'b0; req2 = 1'b0;
    tick(); rel = 1'b0;
    chk_out("prio23_gap", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk_out("prio23_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Profile priority 3/1 -> IE01; holder drop ends grant without timeout
    req1 = 1'b1; req2 = 1'b1; perf1 = 2'd3; perf2 = 2'd1;
    tick(); chk_out("prio31", 1'b1, 1'b0, 1'b1, 1'b0);
    req1 = 1'b0;
    tick(); chk_out("prio31_gap", 1'b0, 1'b0, 1'b1, 1'b0);
    req2 = 1'b0;
    tick(); chk_out("prio31_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // HOLD_MAX timeout: exactly 4 grant cycles then TIMEOUT on first gap cycle
    perf1 = 2'd0; perf2 = 2'd0; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_out($sformatf("tmo_c%0d", i + 1), 1'b1, 1'b0, 1'b1, 1'b0);
    end
    tick(); chk_out("tmo_pulse", 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); chk_out("tmo_end", 1'b0, 1'b0, 1'b0, 1'b0);

    // RELEASE on the 4th cycle: normal release, no TIMEOUT
    for (int i = 0; i < 4; i++) begin
      tick(); chk_out($sformatf("relmax_c%0d", i + 1), 1'b1, 1'b0, 1'b1, 1'b0);
    end
    rel = 1'b1;
    tick(); rel = 1'b0;
    chk_out("relmax_gap", 1'b0, 1'b0, 1'b1, 1'b0);
    req1 = 1'b0;
    tick(); chk_out("relmax_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Tie 2/2 through three grants, starting fresh from reset
    reset = 1'b1; req1 = 1'b1; req2 = 1'b1; perf1 = 2'd2; perf2 = 2'd2;
    tick(); chk_out("tie_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(); chk_out("tie_g1", 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    chk_out("tie_g1_tmo", 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); chk_out("tie_g1_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk_out("tie_g2", rr_g1, rr_g2, 1'b1, 1'b0);
    repeat (4) tick();
    chk_out("tie_g2_tmo", 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); chk_out("tie_g2_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk_out("tie_g3", 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset on the 2nd grant cycle: immediate abort, next tie to IE01
    tick(); chk_out("abort_c2", 1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick(); chk_out("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(); chk_out("abort_tie", 1'b1, 1'b0, 1'b1, 1'b0);

    req1 = 1'b0; req2 = 1'b0;
    tick(); chk_out("final_gap", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk_out("final_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
